// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single RegFile write port between the core
// writeback (requester 0) and the init/seed loader (requester 1).
// One registered output stage feeds RegFile; requester 1 may lock the port
// for a burst; FwdA/FwdB flag read-after-write hazards on the two read ports.
// Build option: define RF_ARB_RR_FAIR_EN for round-robin arbitration in IDLE;
// leave it undefined for fixed priority (requester 0 wins every tie).
//
// Handshake: ReqN is valid, GntN is ready. A transfer happens at a posedge
// where ReqN && GntN. The requester keeps ReqN/AddrN/DestN/DataN stable until
// it sees GntN at an edge. Grants are combinational, mutually exclusive and
// never asserted without the matching request (or while ResetN is low).
//
// DbgState exposes the control state as {LastGnt, Locked}.
module rf_write_arbiter #(
    parameter int W = 8,
    parameter int A = 3
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         Req0,
    input  logic [A-1:0] Addr0,
    input  logic [1:0]   Dest0,
    input  logic [W-1:0] Data0,
    output logic         Gnt0,
    input  logic         Req1,
    input  logic [A-1:0] Addr1,
    input  logic [1:0]   Dest1,
    input  logic [W-1:0] Data1,
    output logic         Gnt1,
    input  logic         Lock1,
    input  logic [A-1:0] RaddrA,
    input  logic [A-1:0] RaddrB,
    output logic         RegWrite,
    output logic [1:0]   RegDest,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         FwdA,
    output logic         FwdB,
    output logic         Locked,
    output logic [1:0]   DbgState
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_LOCK1 = 1'b1
    } state_t;

    // RegDest code that addresses the register file proper
    localparam logic [1:0] DEST_RF = 2'b00;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_last_gnt;
    logic           w_tie_to_1;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_locked;
    logic           w_xfer0;
    logic           w_xfer1;
    logic           w_lock_exit;

    logic           r_reg_write;
    logic [1:0]     r_reg_dest;
    logic [A-1:0]   r_waddr;
    logic [W-1:0]   r_data_in;

    // Tie resolution in IDLE: round-robin favours whoever did not win last,
    // fixed priority always favours requester 0.
`ifdef RF_ARB_RR_FAIR_EN
    assign w_tie_to_1 = ~r_last_gnt;
`else
    assign w_tie_to_1 = 1'b0;
`endif

    assign w_xfer0     = Req0 & w_gnt0;
    assign w_xfer1     = Req1 & w_gnt1;
    assign w_lock_exit = (r_state == ST_LOCK1) && (w_state_nxt == ST_IDLE);

    // State register; reset always lands in IDLE, which also exits a burst
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a locked transfer from requester 1 opens a burst; an
    // unlocked transfer or a dropped Req1 closes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer1 && Lock1) begin
                    w_state_nxt = ST_LOCK1;
                end
            end
            ST_LOCK1: begin
                if (!Req1 || (w_xfer1 && !Lock1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grants and the Locked flag, all forced low during reset
    always_comb begin
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        w_locked = 1'b0;
        if (ResetN) begin
            case (r_state)
                ST_IDLE: begin
                    if (Req0 && Req1) begin
                        w_gnt0 = ~w_tie_to_1;
                        w_gnt1 = w_tie_to_1;
                    end else begin
                        w_gnt0 = Req0;
                        w_gnt1 = Req1;
                    end
                end
                ST_LOCK1: begin
                    w_gnt1   = Req1;
                    w_locked = 1'b1;
                end
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    // LastGnt follows each winner; leaving a burst hands the next tie to req 0
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_last_gnt <= 1'b1;
        end else if (w_xfer0) begin
            r_last_gnt <= 1'b0;
        end else if (w_xfer1 || w_lock_exit) begin
            r_last_gnt <= 1'b1;
        end
    end

    // Output stage: capture the winner's fields; RegWrite pulses for one
    // cycle per transfer, the other fields hold their last value
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_reg_write <= 1'b0;
            r_reg_dest  <= DEST_RF;
            r_waddr     <= '0;
            r_data_in   <= '0;
        end else begin
            r_reg_write <= w_xfer0 | w_xfer1;
            if (w_xfer0) begin
                r_reg_dest <= Dest0;
                r_waddr    <= Addr0;
                r_data_in  <= Data0;
            end else if (w_xfer1) begin
                r_reg_dest <= Dest1;
                r_waddr    <= Addr1;
                r_data_in  <= Data1;
            end
        end
    end

    assign Gnt0     = w_gnt0;
    assign Gnt1     = w_gnt1;
    assign Locked   = w_locked;
    assign DbgState = {r_last_gnt, w_locked};

    assign RegWrite = r_reg_write;
    assign RegDest  = r_reg_dest;
    assign Waddr    = r_waddr;
    assign DataIn   = r_data_in;

    // Forwarding only applies to writes that land in the register file;
    // side targets (LFSR seeds) never alias a register read
    assign FwdA = r_reg_write && (r_reg_dest == DEST_RF) && (r_waddr == RaddrA);
    assign FwdB = r_reg_write && (r_reg_dest == DEST_RF) && (r_waddr == RaddrB);

    // Grant invariants
    a_gnt_exclusive: assert property (@(posedge Clk) disable iff (!ResetN)
        !(Gnt0 && Gnt1));
    a_gnt0_needs_req: assert property (@(posedge Clk) disable iff (!ResetN)
        Gnt0 |-> Req0);
    a_gnt1_needs_req: assert property (@(posedge Clk) disable iff (!ResetN)
        Gnt1 |-> Req1);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued when a
// grant is expected; a negedge monitor pops and compares each RegWrite.
module tb_rf_write_arbiter;

  localparam int W  = 8;
  localparam int A  = 3;
  localparam int PW = W + A + 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic ResetN;
  always #5 Clk = ~Clk;

  logic         Req0, Req1, Lock1;
  logic [A-1:0] Addr0, Addr1, RaddrA, RaddrB;
  logic [1:0]   Dest0, Dest1;
  logic [W-1:0] Data0, Data1;
  logic         Gnt0, Gnt1, RegWrite, FwdA, FwdB, Locked;
  logic [1:0]   RegDest;
  logic [A-1:0] Waddr;
  logic [W-1:0] DataIn;
  logic [1:0]   DbgState;

  rf_write_arbiter #(.W(W), .A(A)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .Req0(Req0), .Addr0(Addr0), .Dest0(Dest0), .Data0(Data0), .Gnt0(Gnt0),
    .Req1(Req1), .Addr1(Addr1), .Dest1(Dest1), .Data1(Data1), .Gnt1(Gnt1),
    .Lock1(Lock1), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .RegWrite(RegWrite), .RegDest(RegDest), .Waddr(Waddr), .DataIn(DataIn),
    .FwdA(FwdA), .FwdB(FwdB), .Locked(Locked), .DbgState(DbgState)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: every RegWrite cycle must match the oldest expected write
  always @(negedge Clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(RegWrite), 32'd0);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        chk("write", 32'({RegDest, Waddr, DataIn}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // apply: drive one cycle's inputs (called just after a negedge), check the
  // grants against the hand-computed expectation and queue the granted write
  task automatic apply(input logic r0, input logic [A-1:0] a0, input logic [1:0] d0,
                       input logic [W-1:0] x0,
                       input logic r1, input logic [A-1:0] a1, input logic [1:0] d1,
                       input logic [W-1:0] x1,
                       input logic l1, input logic [A-1:0] ra, input logic [A-1:0] rb,
                       input logic g0, input logic g1);
    Req0 = r0; Addr0 = a0; Dest0 = d0; Data0 = x0;
    Req1 = r1; Addr1 = a1; Dest1 = d1; Data1 = x1;
    Lock1 = l1; RaddrA = ra; RaddrB = rb;
    #1;
    chk("gnt0", 32'(Gnt0), 32'(g0));
    chk("gnt1", 32'(Gnt1), 32'(g1));
    if (g0) exp_q.push_back({d0, a0, x0});
    if (g1) exp_q.push_back({d1, a1, x1});
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] n0, n1;
  logic         w1;

  initial begin
    // reset with both requests pending
    ResetN = 1'b0;
    Req0 = 1'b1; Addr0 = 3'd1; Dest0 = 2'b00; Data0 = 8'h11;
    Req1 = 1'b1; Addr1 = 3'd2; Dest1 = 2'b00; Data1 = 8'h22;
    Lock1 = 1'b0; RaddrA = 3'd0; RaddrB = 3'd0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_gnt0", 32'(Gnt0), 32'd0);
    chk("rst_gnt1", 32'(Gnt1), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_regdest", 32'(RegDest), 32'd0);
    chk("rst_waddr", 32'(Waddr), 32'd0);
    chk("rst_datain", 32'(DataIn), 32'd0);
    chk("rst_fwda", 32'(FwdA), 32'd0);
    chk("rst_fwdb", 32'(FwdB), 32'd0);
    chk("rst_locked", 32'(Locked), 32'd0);
    chk("rst_dbgstate", 32'(DbgState), 32'd2);

    // release: requester 0 wins the first tie in either build
    @(negedge Clk);
    ResetN = 1'b1;
    apply(1'b1, 3'd1, 2'b00, 8'h11, 1'b1, 3'd2, 2'b00, 8'h22, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    tick();

    // LFSR seed from requester 1; outputs now show the write to r1
    apply(1'b0, 3'd1, 2'b00, 8'h11, 1'b1, 3'd5, 2'b01, 8'h3C, 1'b0, 3'd5, 3'd1, 1'b0, 1'b1);
    chk("w1_regwrite", 32'(RegWrite), 32'd1);
    chk("w1_fwda", 32'(FwdA), 32'd0);
    chk("w1_fwdb", 32'(FwdB), 32'd1);
    tick();

    // contention for 4 cycles (LastGnt is 1 here)
    n0 = 8'h40; n1 = 8'h60;
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_RR_FAIR_EN
      w1 = (i % 2 == 1);
`else
      w1 = 1'b0;
`endif
      apply(1'b1, 3'd4, 2'b00, n0, 1'b1, 3'd6, 2'b00, n1, 1'b0, 3'd5, 3'd5, ~w1, w1);
      if (i == 0) begin
        // the LFSR write is on the port: passed through, no forwarding
        chk("seed_regdest", 32'(RegDest), 32'd1);
        chk("seed_fwda", 32'(FwdA), 32'd0);
        chk("seed_fwdb", 32'(FwdB), 32'd0);
      end
      tick();
      if (w1) n1 = n1 + 8'd1;
      else    n0 = n0 + 8'd1;
    end

    // single write, then forward flags, then idle
    apply(1'b1, 3'd3, 2'b00, 8'hA5, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    tick();
    apply(1'b0, 3'd3, 2'b00, 8'hA5, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 3'd3, 3'd2, 1'b0, 1'b0);
    chk("single_regwrite", 32'(RegWrite), 32'd1);
    chk("single_waddr", 32'(Waddr), 32'd3);
    chk("single_datain", 32'(DataIn), 32'hA5);
    chk("single_fwda", 32'(FwdA), 32'd1);
    chk("single_fwdb", 32'(FwdB), 32'd0);
    tick();
    apply(1'b0, 3'd3, 2'b00, 8'hA5, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0);
    chk("idle_regwrite", 32'(RegWrite), 32'd0);
    chk("idle_fwda", 32'(FwdA), 32'd0);
    tick();

    // burst: 3 locked transfers then an unlocked one, req 0 waiting
    apply(1'b0, 3'd7, 2'b00, 8'h77, 1'b1, 3'd0, 2'b00, 8'hB0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("burst0_locked", 32'(Locked), 32'd0);
    tick();
    apply(1'b1, 3'd7, 2'b00, 8'h77, 1'b1, 3'd1, 2'b00, 8'hB1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("burst1_locked", 32'(Locked), 32'd1);
    chk("burst1_fwda", 32'(FwdA), 32'd1);
    chk("burst1_fwdb", 32'(FwdB), 32'd1);
    tick();
    apply(1'b1, 3'd7, 2'b00, 8'h77, 1'b1, 3'd2, 2'b00, 8'hB2, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("burst2_locked", 32'(Locked), 32'd1);
    tick();
    apply(1'b1, 3'd7, 2'b00, 8'h77, 1'b1, 3'd3, 2'b00, 8'hB3, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("burst3_locked", 32'(Locked), 32'd1);
    tick();
    apply(1'b1, 3'd7, 2'b00, 8'h77, 1'b1, 3'd4, 2'b00, 8'hB4, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk("burst_end_locked", 32'(Locked), 32'd0);
    tick();

    // lock released by Req1 dropping, no transfer that cycle
    apply(1'b0, 3'd7, 2'b00, 8'h78, 1'b1, 3'd4, 2'b00, 8'hB4, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 3'd7, 2'b00, 8'h78, 1'b0, 3'd4, 2'b00, 8'hB4, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("drop_locked", 32'(Locked), 32'd1);
    tick();
    apply(1'b1, 3'd7, 2'b00, 8'h78, 1'b0, 3'd4, 2'b00, 8'hB4, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk("drop_exit_locked", 32'(Locked), 32'd0);
    chk("drop_regwrite", 32'(RegWrite), 32'd0);
    tick();

    // reset asserted mid-burst with a write on the port
    apply(1'b0, 3'd7, 2'b00, 8'h78, 1'b1, 3'd6, 2'b00, 8'hC6, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    apply(1'b0, 3'd7, 2'b00, 8'h78, 1'b1, 3'd7, 2'b00, 8'hC7, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    #1;
    chk("midrst_pre_locked", 32'(Locked), 32'd1);
    chk("midrst_pre_regwrite", 32'(RegWrite), 32'd1);
    ResetN = 1'b0;
    #1;
    chk("midrst_regwrite", 32'(RegWrite), 32'd0);
    chk("midrst_locked", 32'(Locked), 32'd0);
    chk("midrst_waddr", 32'(Waddr), 32'd0);
    chk("midrst_datain", 32'(DataIn), 32'd0);
    chk("midrst_gnt1", 32'(Gnt1), 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    apply(1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 3'd0, 2'b00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    #1;
    chk("final_regwrite", 32'(RegWrite), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
